// File: rtl/dec_queue.sv
// Decoded-op FIFO between the decoder and dispatch. The decoder writes with active-low
// dec_e_, dispatch reads the head with active-low deq_, and is_full gives early back-pressure.
module dec_queue #(
   parameter int DEPTH = 8,
   parameter int ENT   = 128,
   parameter int SLACK = 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             dec_e_,
   input  logic [ENT-1:0]   dec_ent,
   output logic             is_full,
   output logic             que_e_,
   output logic [ENT-1:0]   que_ent,
   input  logic             deq_,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(SLACK);

   // Handshake: an op moves on a rising edge when its active-low strobe is low and the
   // side can take it (push: room or a same-cycle pop; pop: queue not empty).
   logic [ENT-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push, pop;

   always_comb begin
      pop        = !deq_ && (count_q != '0);
      push       = !dec_e_ && ((count_q != DEPTH_C) || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      // A dropped write is an error that must survive a flush; only reset clears it.
      overflow_d = overflow_q | (!dec_e_ && (count_q == DEPTH_C) && !pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; the head is only meaningful while que_e_ is low.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= dec_ent;
   end

   assign que_e_   = (count_q == '0);
   assign que_ent  = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;
   assign is_full  = (DEPTH_C - count_q) <= SLACK_C;

endmodule

// File: tb/tb_dec_queue.sv
// Randomised and directed bench for dec_queue: an abstract queue model feeds a scoreboard
// that a negedge monitor checks against the head, occupancy and flags.
module tb_dec_queue;
   localparam int DEPTH = 8;
   localparam int ENT   = 128;
   localparam int SLACK = 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             dec_e_ = 1'b1;
   logic [ENT-1:0]   dec_ent = '0;
   logic             is_full;
   logic             que_e_;
   logic [ENT-1:0]   que_ent;
   logic             deq_ = 1'b1;
   logic [CNT_W-1:0] count;
   logic             overflow;

   dec_queue #(.DEPTH(DEPTH), .ENT(ENT), .SLACK(SLACK)) dut (
      .clk(clk), .reset(reset), .flush(flush), .dec_e_(dec_e_), .dec_ent(dec_ent),
      .is_full(is_full), .que_e_(que_e_), .que_ent(que_ent), .deq_(deq_),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model state: queue contents, occupancy and sticky error flag.
   logic [ENT-1:0] exp_q[$];
   int             m_cnt = 0;
   bit             m_ovf = 1'b0;
   int             checks = 0;
   int             errors = 0;

   bit             pend_push = 1'b0, pend_pop = 1'b0, pend_flush = 1'b0;
   logic [ENT-1:0] pend_data = '0;

   function automatic void check(input string name, input logic [ENT-1:0] act,
                                 input logic [ENT-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // Apply the previous cycle's inputs to the model using the queue's rules.
   function automatic void commit();
      bit p, q;
      q = pend_pop && (m_cnt != 0);
      p = pend_push && (m_cnt < DEPTH || q);
      if (pend_push && m_cnt == DEPTH && !q) m_ovf = 1'b1;
      if (pend_flush) begin
         exp_q.delete();
         m_cnt = 0;
      end else begin
         if (p) exp_q.push_back(pend_data);
         m_cnt = m_cnt + int'(p) - int'(q);
      end
   endfunction

   task automatic cycle(input bit do_push, input logic [ENT-1:0] d, input bit do_pop,
                        input bit do_flush);
      @(posedge clk);
      #1;
      commit();
      dec_e_     = !do_push;
      dec_ent    = d;
      deq_       = !do_pop;
      flush      = do_flush;
      pend_push  = do_push;
      pend_data  = d;
      pend_pop   = do_pop;
      pend_flush = do_flush;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      dec_e_ = 1'b1; deq_ = 1'b1; flush = 1'b0;
      pend_push = 1'b0; pend_pop = 1'b0; pend_flush = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compare status every cycle, and the head whenever the model holds an entry.
   initial begin
      forever begin
         @(negedge clk);
         check("count", ENT'(count), ENT'(m_cnt));
         check("que_e_", ENT'(que_e_), ENT'(m_cnt == 0));
         check("is_full", ENT'(is_full), ENT'((DEPTH - m_cnt) <= SLACK));
         check("overflow", ENT'(overflow), ENT'(m_ovf));
         if (!reset && m_cnt != 0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard at %0t: model count %0d but no entry queued", $time, m_cnt);
            end else begin
               check("head", que_ent, exp_q[0]);
               if (!deq_) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [ENT-1:0] rd;
      bit             fp, pp, ff;

      do_reset(3);

      for (int i = 1; i <= 8; i++) cycle(1'b1, ENT'(i), 1'b0, 1'b0);
      cycle(1'b1, ENT'(9), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      idle(2);

      for (int i = 0; i < 3; i++) cycle(1'b1, ENT'(16 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, ENT'(32 + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      idle(1);

      cycle(1'b1, ENT'('hA), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(1);

      for (int i = 0; i < 5; i++) cycle(1'b1, ENT'(64 + i), 1'b0, 1'b0);
      cycle(1'b1, ENT'(99), 1'b1, 1'b1);
      cycle(1'b1, ENT'('hB), 1'b0, 1'b0);
      idle(2);

      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         rd = {$urandom, $urandom, $urandom, $urandom};
         fp = ($urandom_range(0, 99) < 60);
         pp = ($urandom_range(0, 99) < 50);
         ff = ($urandom_range(0, 49) == 0);
         if (ff && m_cnt == DEPTH && !pp) fp = 1'b0;
         cycle(fp, rd, pp, ff);
         if ($urandom_range(0, 599) == 0) do_reset(1);
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
